// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader.
//   - FSM state encoding
//   - address / word / byte / count widths and the default load depth
//   - lane_lsb(): bit offset of a byte lane inside the assembled word
package imem_loader_pkg;

  localparam int ADDR_W    = 8;
  localparam int WORD_W    = 32;
  localparam int BYTE_W    = 8;
  localparam int CNT_W     = 9;
  localparam int DEPTH_DEF = 256;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_WRITE = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERR   = 3'd4
  } state_e;

  // Byte k of the stream lands at bit 8*(3-k) when MSB first, else 8*k.
  function automatic logic [4:0] lane_lsb(input logic msb_first, input logic [1:0] idx);
    return msb_first ? {~idx, 3'b000} : {idx, 3'b000};
  endfunction

endpackage

// File: rtl/imem_loader_byte_packer.sv
// byte_packer: assembles four stream bytes into one 32-bit word.
//   clk, rstd  : clock, async active-low reset
//   clr        : restart packing at lane 0 (new load)
//   push       : a byte is accepted this cycle
//   byte_in    : the accepted byte
//   word       : assembled word (lanes per MSB_FIRST)
//   full       : all four lanes written by the most recent push
//   byte_cnt   : lane the next byte will occupy
module byte_packer
  import imem_loader_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rstd,
  input  logic              clr,
  input  logic              push,
  input  logic [BYTE_W-1:0] byte_in,
  output logic [WORD_W-1:0] word,
  output logic              full,
  output logic [1:0]        byte_cnt
);

  logic [WORD_W-1:0] lanes_q, lanes_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              full_q, full_d;

  always_comb begin
    lanes_d = lanes_q;
    cnt_d   = cnt_q;
    full_d  = full_q;
    if (clr) begin
      cnt_d  = 2'd0;
      full_d = 1'b0;
    end else if (push) begin
      lanes_d[lane_lsb(MSB_FIRST, cnt_q) +: BYTE_W] = byte_in;
      cnt_d  = cnt_q + 2'd1;
      full_d = (cnt_q == 2'd3);
    end
  end

  always_ff @(posedge clk or negedge rstd) begin
    if (!rstd) begin
      cnt_q  <= 2'd0;
      full_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      full_q <= full_d;
    end
  end

  // Lane contents are pure data; every lane is rewritten before it is used.
  always_ff @(posedge clk) begin
    lanes_q <= lanes_d;
  end

  assign word     = lanes_q;
  assign full     = full_q;
  assign byte_cnt = cnt_q;

endmodule

// File: rtl/imem_loader.sv
// imem_loader: receives a byte stream and writes it, word by word, into an
// external instruction memory starting at a given word address.
//   clk, rstd                    : clock, async active-low reset
//   start, base                  : begin a load at word address base
//   in_valid/in_data/in_last     : byte stream in; in_ready accepts a byte
//   wr_en/wr_addr/wr_data        : instruction memory write port
//   busy, done, err, words       : status (done/err sticky until next start)
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b1,
  parameter int DEPTH     = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rstd,
  input  logic              start,
  input  logic [ADDR_W-1:0] base,
  input  logic              in_valid,
  input  logic [BYTE_W-1:0] in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [WORD_W-1:0] wr_data,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [CNT_W-1:0]  words
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  words_q, words_d;
  logic              last_q, last_d;

  logic              start_ok;
  logic              hs;
  logic [WORD_W-1:0] pk_word;
  logic              pk_full;
  logic [1:0]        pk_cnt;

  assign start_ok = start && (state_q == ST_IDLE || state_q == ST_DONE || state_q == ST_ERR);
  assign hs       = in_valid && (state_q == ST_LOAD);

  byte_packer #(.MSB_FIRST(MSB_FIRST)) u_packer (
    .clk      (clk),
    .rstd     (rstd),
    .clr      (start_ok),
    .push     (hs),
    .byte_in  (in_data),
    .word     (pk_word),
    .full     (pk_full),
    .byte_cnt (pk_cnt)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    words_d = words_q;
    last_d  = last_q;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start_ok) begin
          state_d = ST_LOAD;
          addr_d  = base;
          words_d = '0;
          last_d  = 1'b0;
        end
      end
      ST_LOAD: begin
        if (hs) begin
          if (pk_cnt == 2'd3) begin
            state_d = ST_WRITE;
            last_d  = in_last;
          end else if (in_last) begin
            // Image ended mid-word: the partial word is dropped.
            state_d = ST_ERR;
          end
        end
      end
      ST_WRITE: begin
        addr_d  = addr_q + 8'd1;
        words_d = words_q + 9'd1;
        if (last_q)
          state_d = ST_DONE;
        else if (words_q + 9'd1 == CNT_W'(DEPTH))
          state_d = ST_ERR;
        else
          state_d = ST_LOAD;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstd) begin
    if (!rstd) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      words_q <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      words_q <= words_d;
      last_q  <= last_d;
    end
  end

  assign in_ready = (state_q == ST_LOAD);
  assign busy     = (state_q == ST_LOAD) || (state_q == ST_WRITE);
  assign done     = (state_q == ST_DONE);
  assign err      = (state_q == ST_ERR);
  assign words    = words_q;
  assign wr_en    = (state_q == ST_WRITE) && pk_full;
  assign wr_addr  = addr_q;
  // Word is only presented during the write strobe so reset shows zero.
  assign wr_data  = wr_en ? pk_word : '0;

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter MSB_FIRST, default 1, meaning: 1 puts the first byte of a word in wr_data[31:24]; 0 puts it in wr_data[7:0].
REQ-002 Parameter DEPTH, default 256, meaning: maximum words per load, equal to the instruction memory depth.
REQ-003 clk  input  1  clock; all state changes on posedge clk.
REQ-004 rstd  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  single-cycle pulse that begins a load.
REQ-006 base  input  8  start word address, sampled on the start cycle.
REQ-007 in_valid  input  1  byte-stream valid.
REQ-008 in_data  input  8  byte-stream data.
REQ-009 in_last  input  1  marks the final byte of the image.
REQ-010 in_ready  output  1  loader accepts a byte this cycle.
REQ-011 wr_en  output  1  instruction memory write strobe.
REQ-012 wr_addr  output  8  instruction memory word address.
REQ-013 wr_data  output  32  instruction word.
REQ-014 busy  output  1  high in LOAD or WRITE.
REQ-015 done  output  1  load completed cleanly; sticky.
REQ-016 err  output  1  load aborted; sticky.
REQ-017 words  output  9  count of words written in the current or last load.

Function
REQ-018 The FSM SHALL have the states IDLE, LOAD, WRITE, DONE and ERR.
REQ-019 A byte handshake SHALL occur only on a cycle where in_valid=1 and in_ready=1; in_ready SHALL be 1 only in LOAD.
REQ-020 IDLE/DONE/ERR + start=1 -> LOAD; same edge: addr<=base, byte_cnt<=0, words<=0, done<=0, err<=0.
REQ-021 start SHALL be ignored in LOAD and WRITE.
REQ-022 In LOAD, each handshake SHALL store in_data in byte lane byte_cnt (mapped per MSB_FIRST) and increment byte_cnt modulo 4.
REQ-023 A handshake with byte_cnt=3 SHALL move the FSM to WRITE.
REQ-024 In WRITE, for exactly one cycle: wr_en=1, wr_addr=addr, wr_data=the assembled word; in_ready=0.
REQ-025 Write latency SHALL be one cycle: wr_en asserts on the cycle after the 4th-byte handshake.
REQ-026 Peak throughput SHALL be 4 bytes per 5 cycles.
REQ-027 On leaving WRITE: addr<=addr+1 (modulo 256, so the address wraps 0xFF -> 0x00); words<=words+1.
REQ-028 WRITE exit when the 4th byte carried in_last=1: go to DONE.
REQ-029 WRITE exit when in_last=0 and words+1=DEPTH: go to ERR (overflow).
REQ-030 WRITE exit in all other cases: return to LOAD.
REQ-031 A handshake with in_last=1 and byte_cnt!=3 SHALL go to ERR (partial word); no write SHALL occur for that partial word.
REQ-032 done SHALL be 1 in DONE; err SHALL be 1 in ERR; both hold until the next start.
REQ-033 wr_en SHALL be 0 in every state except WRITE.
REQ-034 in_valid with in_ready=0 SHALL have no effect, and the byte is not consumed.
REQ-035 words SHALL keep its final value in DONE and ERR.

Reset
REQ-036 rstd=0 SHALL immediately force state=IDLE, in_ready=0, wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0, err=0, words=0, byte_cnt=0.
REQ-037 A reset during LOAD or WRITE SHALL abandon the load with no further writes; a word pending in WRITE SHALL not be written if reset is asserted before its wr_en cycle.
REQ-038 Reset release SHALL take effect on the first posedge clk with rstd=1.

Structure
REQ-039 A shared package SHALL hold the FSM state encodings, the width constants (address 8, word 32, byte 8, count 9) and the DEPTH default.
REQ-040 The block SHALL contain one sub-module, byte_packer: a 4-byte lane register with byte counter, parameterised by MSB_FIRST, with outputs word and full.
REQ-041 The instruction memory SHALL stay external; its write port is driven by wr_en/wr_addr/wr_data.

Verification
REQ-042 base=0x10, bytes 00 11 22 33 44 55 66 77, last on 0x77, MSB_FIRST=1 -> writes [0x10]=0x00112233 and [0x11]=0x44556677; done=1, words=2.
REQ-043 Same stream with MSB_FIRST=0 -> [0x10]=0x33221100, [0x11]=0x77665544.
REQ-044 base=0xFF, 2 words -> wr_addr sequence 0xFF then 0x00; done=1.
REQ-045 base=0, 6 bytes with last on byte 6 -> exactly 1 write; err=1, words=1, then in_ready=0.
REQ-046 DEPTH=4, 20 bytes, no in_last -> 4 writes, then err=1, words=4.
REQ-047 in_valid toggled randomly during a 3-word load -> identical memory contents to the gap-free run.
REQ-048 rstd pulsed low on the WRITE cycle of word 2 -> no wr_en for word 2, all outputs 0; a new start then reloads correctly.
